hazard_sequencer: RTL and testbench
===================================

// Module: hazard_sequencer
// PURPOSE
//   Pipeline hazard controller for the 5-stage MIPS core. It sequences the stall, flush and freeze
//   signals that gate the PC, IF/ID, ID/EX and the downstream pipeline registers.
//   It sits beside the opcode decoder: it inserts load-use bubbles, squashes wrong-path
//   instructions after a taken branch, and freezes the whole pipe on a data-memory wait.
//   It also keeps saturating performance counters and a sticky memory-timeout flag.
// PARAMETERS
//   LU_STALL  1    load-use stall length in cycles (1..3)
//   BR_FLUSH  1    taken-branch flush length in cycles (1..3)
//   CNT_W     16   width of each performance counter
//   MEM_TMO   255  consecutive freeze cycles that raise mem_timeout (>=1)
// PORTS
//   clk          in   1      clock, rising edge
//   rst_n        in   1      asynchronous reset, active low
//   id_rs        in   5      rs of the instruction in ID
//   id_rt        in   5      rt of the instruction in ID
//   id_uses_rt   in   1      ID instruction reads rt as a source
//   ex_rt        in   5      destination rt of the instruction in EX
//   ex_mem_read  in   1      instruction in EX is a load
//   branch_taken in   1      branch resolved taken in EX (target valid this cycle)
//   mem_req      in   1      MEM stage is accessing data memory
//   mem_ready    in   1      data memory completes the access this cycle
//   perf_clr     in   1      synchronous clear of the performance counters
//   pc_write     out  1      PC load enable
//   ifid_write   out  1      IF/ID load enable
//   ifid_flush   out  1      IF/ID loads a NOP
//   idex_bubble  out  1      ID/EX loads zeroed control (bubble)
//   pipe_hold    out  1      ID/EX, EX/MEM and MEM/WB hold their contents
//   hz_state     out  2      FSM state: 0 RUN, 1 LDUSE, 2 FLUSH
//   stall_cnt    out  CNT_W  cycles with pc_write=0 (stall or freeze)
//   flush_cnt    out  CNT_W  cycles with ifid_flush=1
//   mem_timeout  out  1      sticky: the freeze run reached MEM_TMO
// BEHAVIOUR
//   Definitions
//   - load_use = ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
//   - freeze = mem_req && !mem_ready.
//   Output patterns (combinational)
//   - NORMAL: pc_write=1, ifid_write=1, all others 0.
//   - STALL: pc_write=0, ifid_write=0, idex_bubble=1.
//   - FLUSH: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1.
//   - FREEZE: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=0, pipe_hold=1.
//   Reset
//   - While rst_n=0, all five control outputs are 0.
//   - Reset clears state to RUN and clears cnt, both counters, the freeze run and mem_timeout.
//   - Asserting rst_n mid-sequence abandons the sequence; there is no resume.
//   Freeze
//   - freeze overrides everything in every state: the FREEZE pattern is driven, and state and cnt hold.
//   - The first cycle with mem_ready=1 resumes the held state. That cycle uses the normal rules.
//   FSM state RUN (Mealy, in priority order)
//   - branch_taken: drive FLUSH. If BR_FLUSH>1, load cnt=BR_FLUSH-1 and go to FLUSH.
//   - else load_use: drive STALL. If LU_STALL>1, load cnt=LU_STALL-1 and go to LDUSE.
//   - else: drive NORMAL.
//   - branch_taken together with load_use -> FLUSH only, because the stalled ID instruction is squashed.
//   FSM states LDUSE and FLUSH
//   - Drive STALL or FLUSH respectively, and decrement cnt.
//   - Return to RUN in the cycle where cnt==1.
//   - Inputs branch_taken and load_use are ignored in these states. The EX stage holds a bubble there.
//   Latency
//   - Hazard response is combinational (same cycle).
//   - Exactly LU_STALL stall cycles per load-use hazard, and exactly BR_FLUSH flush cycles per taken branch.
//   - Freeze cycles come on top of these counts.
//   Counters
//   - stall_cnt increments on each clock edge where pc_write=0.
//   - flush_cnt increments on each clock edge where ifid_flush=1.
//   - Both saturate at all-ones with no wrap.
//   - perf_clr has priority over an increment in the same cycle.
//   Memory timeout
//   - The freeze-run counter increments each freeze cycle, saturates, and resets to 0 on any non-freeze cycle.
//   - mem_timeout sets on the edge where the run reaches MEM_TMO and stays set until rst_n.
// TESTING
//   Load-use hazard
//   - ex_mem_read=1, ex_rt=5, id_rs=5 -> 1 cycle of STALL, then NORMAL; stall_cnt=1.
//   - Same stimulus with ex_rt=0 -> no stall.
//   Branch flush with BR_FLUSH=2
//   - branch_taken at t -> ifid_flush=1 at t and t+1, hz_state=2 at t+1, RUN at t+2; flush_cnt=2.
//   Branch and load-use together
//   - branch_taken=1 and load_use=1 at t -> FLUSH pattern only, pc_write=1; stall_cnt unchanged.
//   Freeze during a stall with LU_STALL=2
//   - Load-use at t; freeze at t+1..t+3 -> FREEZE for 3 cycles, state held at LDUSE.
//   - Remaining STALL cycle at t+4, RUN at t+5; stall_cnt=5.
//   Timeout and saturation with MEM_TMO=4, CNT_W=2
//   - 6 freeze cycles -> mem_timeout=1 from edge 4, still 1 after mem_ready; stall_cnt sticks at 3.
//   - Then perf_clr together with an increment -> stall_cnt=0.
//   Reset mid-flush with BR_FLUSH=3
//   - rst_n low during FLUSH -> outputs 0, hz_state=0, counters 0.
//   - After release -> NORMAL pattern with no residual flush.

Source files
------------

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: pipeline hazard controller for the 5-stage MIPS core.
// It drives the PC, IF/ID and ID/EX enables for load-use bubbles and
// taken-branch squashes, and freezes the whole pipe while data memory waits.
// It also keeps two saturating performance counters and a sticky timeout flag.
module hazard_sequencer #(
  parameter int LU_STALL = 1,    // load-use stall length (1..3)
  parameter int BR_FLUSH = 1,    // taken-branch flush length (1..3)
  parameter int CNT_W    = 16,   // performance counter width
  parameter int MEM_TMO  = 255   // freeze run length that raises mem_timeout (>=1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rt,
  input  logic             ex_mem_read,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             perf_clr,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_hold,
  output logic [1:0]       hz_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LDUSE = 2'd1,
    FLUSH = 2'd2
  } hzState_t;

  // Sequence lengths are at most 3, so a 2-bit down-counter suffices.
  localparam logic [1:0] LU_LOAD = 2'(LU_STALL - 1);
  localparam logic [1:0] BR_LOAD = 2'(BR_FLUSH - 1);

  // The freeze run saturates at MEM_TMO, so it only needs to hold that value.
  localparam int             TMO_W   = $clog2(MEM_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(MEM_TMO);

  hzState_t         stateReg;
  logic [1:0]       cntReg;
  logic [TMO_W-1:0] freezeRunReg;
  logic             memTimeoutReg;

  logic loadUse;
  logic freeze;

  assign loadUse = ex_mem_read && (ex_rt != 5'd0) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign freeze  = mem_req && !mem_ready;

  // Mealy output decode: reset forces all enables low, freeze beats every state.
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    if (!rst_n) begin
      pc_write = 1'b0;
    end else if (freeze) begin
      pipe_hold = 1'b1;
    end else begin
      unique case (stateReg)
        LDUSE: begin
          idex_bubble = 1'b1;
        end
        FLUSH: begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end
        default: begin
          if (branch_taken) begin
            // A branch squashes the ID instruction, so any load-use on it is moot.
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (loadUse) begin
            idex_bubble = 1'b1;
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
          end
        end
      endcase
    end
  end

  // Sequencer state and remaining-cycle count; both hold while frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= RUN;
      cntReg   <= 2'd0;
    end else if (!freeze) begin
      unique case (stateReg)
        LDUSE, FLUSH: begin
          cntReg <= cntReg - 2'd1;
          if (cntReg == 2'd1) begin
            stateReg <= RUN;
          end
        end
        default: begin
          // The first hazard cycle is the RUN cycle itself, hence length-1 remain.
          if (branch_taken) begin
            if (BR_FLUSH > 1) begin
              cntReg   <= BR_LOAD;
              stateReg <= FLUSH;
            end
          end else if (loadUse) begin
            if (LU_STALL > 1) begin
              cntReg   <= LU_LOAD;
              stateReg <= LDUSE;
            end
          end
        end
      endcase
    end
  end

  // Consecutive-freeze tracker and the sticky timeout it raises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freezeRunReg  <= '0;
      memTimeoutReg <= 1'b0;
    end else if (freeze) begin
      if (freezeRunReg != TMO_LIM) begin
        freezeRunReg <= freezeRunReg + TMO_W'(1);
      end
      if (freezeRunReg == TMO_LIM - TMO_W'(1)) begin
        memTimeoutReg <= 1'b1;
      end
    end else begin
      freezeRunReg <= '0;
    end
  end

  // Event 0 counts stall/freeze cycles, event 1 counts flush cycles.
  logic [1:0] perfInc;
  assign perfInc = {ifid_flush, ~pc_write};

  for (genvar gi = 0; gi < 2; gi++) begin : gPerf
    logic [CNT_W-1:0] cntValReg;

    // Saturating event counter; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cntValReg <= '0;
      end else if (perf_clr) begin
        cntValReg <= '0;
      end else if (perfInc[gi] && (cntValReg != '1)) begin
        cntValReg <= cntValReg + CNT_W'(1);
      end
    end
  end

  assign stall_cnt   = gPerf[0].cntValReg;
  assign flush_cnt   = gPerf[1].cntValReg;
  assign hz_state    = stateReg;
  assign mem_timeout = memTimeoutReg;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer. Three instances with different
// parameter sets share one stimulus bus; each scenario resets all of them
// and checks only the instance whose parameters it targets.
module tb_hazard_sequencer;

  // Control vector order: {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold}
  localparam logic [4:0] P_OFF    = 5'b00000;
  localparam logic [4:0] P_NORMAL = 5'b11000;
  localparam logic [4:0] P_STALL  = 5'b00010;
  localparam logic [4:0] P_FLUSH  = 5'b11110;
  localparam logic [4:0] P_FREEZE = 5'b00001;

  logic       clk = 1'b0;
  logic       rstN;
  logic [4:0] idRs, idRt, exRt;
  logic       idUsesRt, exMemRead, branchTaken, memReq, memReady, perfClr;

  // A: LU_STALL=1 BR_FLUSH=2; B: LU_STALL=2 BR_FLUSH=3; C: CNT_W=2 MEM_TMO=4
  logic [4:0]  ctlA, ctlB, ctlC;
  logic [1:0]  hzA, hzB, hzC;
  logic [15:0] stallA, flushA, stallB, flushB;
  logic [1:0]  stallC, flushC;
  logic        tmoA, tmoB, tmoC;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_sequencer #(.LU_STALL(1), .BR_FLUSH(2), .CNT_W(16), .MEM_TMO(255)) dutA (
    .clk(clk), .rst_n(rstN), .id_rs(idRs), .id_rt(idRt), .id_uses_rt(idUsesRt),
    .ex_rt(exRt), .ex_mem_read(exMemRead), .branch_taken(branchTaken),
    .mem_req(memReq), .mem_ready(memReady), .perf_clr(perfClr),
    .pc_write(ctlA[4]), .ifid_write(ctlA[3]), .ifid_flush(ctlA[2]),
    .idex_bubble(ctlA[1]), .pipe_hold(ctlA[0]), .hz_state(hzA),
    .stall_cnt(stallA), .flush_cnt(flushA), .mem_timeout(tmoA));

  hazard_sequencer #(.LU_STALL(2), .BR_FLUSH(3), .CNT_W(16), .MEM_TMO(255)) dutB (
    .clk(clk), .rst_n(rstN), .id_rs(idRs), .id_rt(idRt), .id_uses_rt(idUsesRt),
    .ex_rt(exRt), .ex_mem_read(exMemRead), .branch_taken(branchTaken),
    .mem_req(memReq), .mem_ready(memReady), .perf_clr(perfClr),
    .pc_write(ctlB[4]), .ifid_write(ctlB[3]), .ifid_flush(ctlB[2]),
    .idex_bubble(ctlB[1]), .pipe_hold(ctlB[0]), .hz_state(hzB),
    .stall_cnt(stallB), .flush_cnt(flushB), .mem_timeout(tmoB));

  hazard_sequencer #(.LU_STALL(1), .BR_FLUSH(1), .CNT_W(2), .MEM_TMO(4)) dutC (
    .clk(clk), .rst_n(rstN), .id_rs(idRs), .id_rt(idRt), .id_uses_rt(idUsesRt),
    .ex_rt(exRt), .ex_mem_read(exMemRead), .branch_taken(branchTaken),
    .mem_req(memReq), .mem_ready(memReady), .perf_clr(perfClr),
    .pc_write(ctlC[4]), .ifid_write(ctlC[3]), .ifid_flush(ctlC[2]),
    .idex_bubble(ctlC[1]), .pipe_hold(ctlC[0]), .hz_state(hzC),
    .stall_cnt(stallC), .flush_cnt(flushC), .mem_timeout(tmoC));

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic clearInputs();
    idRs = 5'd0; idRt = 5'd0; exRt = 5'd0; idUsesRt = 1'b0; exMemRead = 1'b0;
    branchTaken = 1'b0; memReq = 1'b0; memReady = 1'b0; perfClr = 1'b0;
  endtask

  // Advance one edge; inputs change and outputs are sampled 1-2 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic doReset();
    clearInputs();
    rstN = 1'b0;
    tick();
    tick();
    rstN = 1'b1;
  endtask

  initial begin
    clearInputs();
    rstN = 1'b0;
    tick();
    settle();
    checkEq("reset ctlA", 32'(ctlA), 32'(P_OFF));
    checkEq("reset hzA", 32'(hzA), 32'd0);
    checkEq("reset stallA", 32'(stallA), 32'd0);
    checkEq("reset flushA", 32'(flushA), 32'd0);
    checkEq("reset tmoA", 32'(tmoA), 32'd0);
    tick();
    rstN = 1'b1;
    settle();
    checkEq("idle ctlA normal", 32'(ctlA), 32'(P_NORMAL));

    // Load-use on rs: one stall cycle, then normal.
    exMemRead = 1'b1; exRt = 5'd5; idRs = 5'd5;
    settle();
    checkEq("lu rs ctlA stall", 32'(ctlA), 32'(P_STALL));
    tick();
    clearInputs();
    settle();
    checkEq("lu after ctlA normal", 32'(ctlA), 32'(P_NORMAL));
    checkEq("lu after hzA", 32'(hzA), 32'd0);
    checkEq("lu stallA", 32'(stallA), 32'd1);

    // Register 0 never creates a hazard.
    exMemRead = 1'b1; exRt = 5'd0; idRs = 5'd0;
    settle();
    checkEq("lu r0 ctlA normal", 32'(ctlA), 32'(P_NORMAL));

    // rt match only counts when ID actually reads rt.
    exRt = 5'd7; idRs = 5'd3; idRt = 5'd7; idUsesRt = 1'b0;
    settle();
    checkEq("lu rt unused ctlA", 32'(ctlA), 32'(P_NORMAL));
    idUsesRt = 1'b1;
    settle();
    checkEq("lu rt used ctlA", 32'(ctlA), 32'(P_STALL));
    tick();
    clearInputs();
    settle();
    checkEq("lu rt stallA", 32'(stallA), 32'd2);

    // Taken branch with BR_FLUSH=2.
    doReset();
    branchTaken = 1'b1;
    settle();
    checkEq("br t ctlA flush", 32'(ctlA), 32'(P_FLUSH));
    checkEq("br t hzA", 32'(hzA), 32'd0);
    tick();
    branchTaken = 1'b0;
    settle();
    checkEq("br t+1 ctlA flush", 32'(ctlA), 32'(P_FLUSH));
    checkEq("br t+1 hzA", 32'(hzA), 32'd2);
    tick();
    settle();
    checkEq("br t+2 ctlA normal", 32'(ctlA), 32'(P_NORMAL));
    checkEq("br t+2 hzA", 32'(hzA), 32'd0);
    checkEq("br flushA", 32'(flushA), 32'd2);

    // Branch and load-use together: flush only.
    doReset();
    branchTaken = 1'b1; exMemRead = 1'b1; exRt = 5'd9; idRs = 5'd9;
    settle();
    checkEq("br+lu ctlA flush", 32'(ctlA), 32'(P_FLUSH));
    tick();
    clearInputs();
    tick();
    settle();
    checkEq("br+lu stallA", 32'(stallA), 32'd0);
    checkEq("br+lu flushA", 32'(flushA), 32'd2);

    // Freeze in the middle of a 2-cycle load-use stall (instance B).
    doReset();
    exMemRead = 1'b1; exRt = 5'd4; idRs = 5'd4;
    settle();
    checkEq("frz t ctlB stall", 32'(ctlB), 32'(P_STALL));
    tick();
    clearInputs();
    memReq = 1'b1; memReady = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      settle();
      checkEq($sformatf("frz t+%0d ctlB", i), 32'(ctlB), 32'(P_FREEZE));
      checkEq($sformatf("frz t+%0d hzB", i), 32'(hzB), 32'd1);
      tick();
    end
    memReady = 1'b1;
    settle();
    checkEq("frz t+4 ctlB stall", 32'(ctlB), 32'(P_STALL));
    checkEq("frz t+4 hzB", 32'(hzB), 32'd1);
    tick();
    clearInputs();
    settle();
    checkEq("frz t+5 ctlB normal", 32'(ctlB), 32'(P_NORMAL));
    checkEq("frz t+5 hzB", 32'(hzB), 32'd0);
    checkEq("frz stallB", 32'(stallB), 32'd5);

    // Timeout and 2-bit counter saturation (instance C, MEM_TMO=4).
    doReset();
    memReq = 1'b1; memReady = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checkEq($sformatf("tmo edge%0d tmoC", k), 32'(tmoC), (k >= 4) ? 32'd1 : 32'd0);
      checkEq($sformatf("tmo edge%0d stallC", k), 32'(stallC), (k >= 3) ? 32'd3 : 32'(k));
    end
    memReady = 1'b1;
    settle();
    checkEq("tmo ready ctlC normal", 32'(ctlC), 32'(P_NORMAL));
    tick();
    checkEq("tmo sticky tmoC", 32'(tmoC), 32'd1);
    memReady = 1'b0; perfClr = 1'b1;
    tick();
    checkEq("tmo clr stallC", 32'(stallC), 32'd0);
    checkEq("tmo clr tmoC", 32'(tmoC), 32'd1);
    clearInputs();

    // Reset in the middle of a 3-cycle flush (instance B).
    doReset();
    branchTaken = 1'b1;
    tick();
    branchTaken = 1'b0;
    settle();
    checkEq("rstfl pre hzB", 32'(hzB), 32'd2);
    checkEq("rstfl pre flushB", 32'(flushB), 32'd1);
    rstN = 1'b0;
    settle();
    checkEq("rstfl ctlB off", 32'(ctlB), 32'(P_OFF));
    checkEq("rstfl hzB", 32'(hzB), 32'd0);
    checkEq("rstfl flushB", 32'(flushB), 32'd0);
    checkEq("rstfl stallB", 32'(stallB), 32'd0);
    tick();
    rstN = 1'b1;
    settle();
    checkEq("rstfl rel ctlB normal", 32'(ctlB), 32'(P_NORMAL));
    tick();
    settle();
    checkEq("rstfl rel+1 ctlB normal", 32'(ctlB), 32'(P_NORMAL));
    checkEq("rstfl rel+1 flushB", 32'(flushB), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
